// File: rtl/digit_pkg.sv
// rtl/digit_pkg.sv - shared scan state encoding, coordinate widths and default frame geometry
package digit_pkg;

    typedef enum logic [1:0] {
        WAIT_VS   = 2'd0,
        WAIT_LINE = 2'd1,
        ACTIVE    = 2'd2
    } scan_state_t;

    localparam int COORD_W      = 9;
    // One extra bit so a counter saturated at 512 is representable.
    localparam int COUNT_W      = COORD_W + 1;
    localparam int DEF_H_ACTIVE = 320;
    localparam int DEF_V_ACTIVE = 240;

    function automatic logic [COUNT_W-1:0] sat_inc(
        input logic [COUNT_W-1:0] value,
        input logic [COUNT_W-1:0] limit
    );
        return (value >= limit) ? limit : value + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - registered rise/fall detector for a level input
module sync_edge_det (
    input  logic clock,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/fg_pixel_scan.sv
// rtl/fg_pixel_scan.sv - binarising raster scanner emitting foreground pixel coordinates
// Optional region-of-interest gating of fg_wren is enabled with macro FG_ROI_EN.
module fg_pixel_scan
    import digit_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int ROI_X0   = 0,
    parameter int ROI_X1   = 319,
    parameter int ROI_Y0   = 0,
    parameter int ROI_Y1   = 239
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               pix_de,
    input  logic [7:0]         pix_data,
    input  logic [7:0]         threshold,
    output logic [COORD_W-1:0] x_coord,
    output logic [COORD_W-1:0] y_coord,
    output logic               fg_wren,
    output logic               frame_start
);

    localparam logic [COUNT_W-1:0] H_LIM  = COUNT_W'(H_ACTIVE);
    localparam logic [COUNT_W-1:0] V_LIM  = COUNT_W'(V_ACTIVE);
    localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_ACTIVE - 1);

    scan_state_t        state;
    scan_state_t        state_nx;
    logic [COUNT_W-1:0] col;
    logic [COUNT_W-1:0] row;
    logic [COUNT_W-1:0] cur_col;
    logic               vs_rise;
    logic               vs_fall_unused;
    logic               de_rise;
    logic               de_fall;
    logic               proc;
    logic               is_fg;
    logic               in_frame;
    logic               in_roi;
    logic               hit;

    sync_edge_det u_vs_edge (
        .clock (clock),
        .rst_n (rst_n),
        .sig   (vsync),
        .rise  (vs_rise),
        .fall  (vs_fall_unused)
    );

    sync_edge_det u_de_edge (
        .clock (clock),
        .rst_n (rst_n),
        .sig   (pix_de),
        .rise  (de_rise),
        .fall  (de_fall)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nx;
        end
    end

    // A vsync rise overrides everything, abandoning any partial line.
    always_comb begin
        state_nx = state;
        if (vs_rise) begin
            state_nx = WAIT_LINE;
        end else begin
            case (state)
                WAIT_VS:   state_nx = WAIT_VS;
                WAIT_LINE: if (de_rise) state_nx = ACTIVE;
                ACTIVE: begin
                    if (de_fall) begin
                        state_nx = (row == V_LAST) ? WAIT_VS : WAIT_LINE;
                    end
                end
                default:   state_nx = WAIT_VS;
            endcase
        end
    end

    // The rising-edge pixel in WAIT_LINE is processed as column 0.
    always_comb begin
        cur_col  = (state == ACTIVE) ? col : '0;
        proc     = 1'b0;
        if (!vs_rise && pix_de) begin
            proc = (state == ACTIVE) || ((state == WAIT_LINE) && de_rise);
        end
        is_fg    = pix_data < threshold;
        in_frame = (cur_col < H_LIM) && (row < V_LIM);
        hit      = proc && is_fg && in_frame && in_roi;
    end

`ifdef FG_ROI_EN
    localparam logic [COUNT_W-1:0] RX0 = COUNT_W'(ROI_X0);
    localparam logic [COUNT_W-1:0] RX1 = COUNT_W'(ROI_X1);
    localparam logic [COUNT_W-1:0] RY0 = COUNT_W'(ROI_Y0);
    localparam logic [COUNT_W-1:0] RY1 = COUNT_W'(ROI_Y1);

    assign in_roi = (cur_col >= RX0) && (cur_col <= RX1) &&
                    (row >= RY0) && (row <= RY1);
`else
    localparam bit roi_cfg_unused = (ROI_X0 <= ROI_X1) && (ROI_Y0 <= ROI_Y1);

    assign in_roi = 1'b1;
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            if (vs_rise) begin
                row <= '0;
            end else if ((state == ACTIVE) && de_fall) begin
                row <= sat_inc(row, V_LIM);
            end
            if (proc) begin
                col <= sat_inc(cur_col, H_LIM);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            x_coord     <= '0;
            y_coord     <= '0;
            fg_wren     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (proc && in_frame) begin
                x_coord <= cur_col[COORD_W-1:0];
                y_coord <= row[COORD_W-1:0];
            end
            fg_wren     <= hit;
            frame_start <= vs_rise;
        end
    end

endmodule

// File: tb/tb_fg_pixel_scan.sv
// tb/tb_fg_pixel_scan.sv - self-checking bench for fg_pixel_scan
module tb_fg_pixel_scan;
    import digit_pkg::*;

    localparam int H   = 320;
    localparam int V   = 240;
    localparam int RX0 = 10;
    localparam int RX1 = 19;
    localparam int RY0 = 3;
    localparam int RY1 = 4;

    logic               clock     = 1'b0;
    logic               rst_n     = 1'b0;
    logic               vsync     = 1'b0;
    logic               pix_de    = 1'b0;
    logic [7:0]         pix_data  = 8'd0;
    logic [7:0]         threshold = 8'd0;
    logic [COORD_W-1:0] x_coord;
    logic [COORD_W-1:0] y_coord;
    logic               fg_wren;
    logic               frame_start;

    fg_pixel_scan #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ROI_X0   (RX0),
        .ROI_X1   (RX1),
        .ROI_Y0   (RY0),
        .ROI_Y1   (RY1)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .pix_de      (pix_de),
        .pix_data    (pix_data),
        .threshold   (threshold),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .fg_wren     (fg_wren),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
    } coord_t;

    typedef struct {
        logic [7:0] thr;
        logic [7:0] data;
        int         exp_n;
    } thr_vec_t;

    coord_t   exp_q[$];
    coord_t   mon_e;
    thr_vec_t vecs[7];
    int tests    = 0;
    int fails    = 0;
    int strobes  = 0;
    int pushes   = 0;
    int fs_count = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (frame_start) begin
            fs_count++;
            if (fg_wren) check("frame_start_with_wren", 1, 0);
        end
        if (fg_wren) begin
            strobes++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_xy", int'(x_coord) * 1000 + int'(y_coord), -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_x", int'(x_coord), mon_e.x);
                check("strobe_y", int'(y_coord), mon_e.y);
            end
        end
    end

    task automatic push_exp(input int x, input int y);
        coord_t c;
        c.x = x;
        c.y = y;
`ifdef FG_ROI_EN
        if (x >= RX0 && x <= RX1 && y >= RY0 && y <= RY1) begin
            exp_q.push_back(c);
            pushes++;
        end
`else
        exp_q.push_back(c);
        pushes++;
`endif
    endtask

    task automatic cyc(input logic vs, input logic de, input logic [7:0] d);
        vsync    = vs;
        pix_de   = de;
        pix_data = d;
        @(posedge clock);
        #1;
    endtask

    task automatic vs_pulse();
        repeat (2) cyc(1'b1, 1'b0, 8'd0);
        repeat (2) cyc(1'b0, 1'b0, 8'd0);
    endtask

    // row < 0 marks a line the scanner must ignore.
    task automatic send_line(input int len, input int row, input logic [7:0] base,
                             input int spot, input logic [7:0] spot_val);
        logic [7:0] v;
        for (int c = 0; c < len; c++) begin
            v = (c == spot) ? spot_val : base;
            if (row >= 0 && c < H && v < threshold) push_exp(c, row);
            cyc(1'b0, 1'b1, v);
        end
        repeat (4) cyc(1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        int s0;
        int p0;
        int f0;
        int reset_bad;

        vecs[0] = '{thr: 8'd0,   data: 8'd0,   exp_n: 0};
        vecs[1] = '{thr: 8'd255, data: 8'd254, exp_n: 1};
        vecs[2] = '{thr: 8'd255, data: 8'd255, exp_n: 0};
        vecs[3] = '{thr: 8'd128, data: 8'd127, exp_n: 1};
        vecs[4] = '{thr: 8'd128, data: 8'd128, exp_n: 0};
        vecs[5] = '{thr: 8'd1,   data: 8'd0,   exp_n: 1};
        vecs[6] = '{thr: 8'd200, data: 8'd50,  exp_n: 1};

        #1;
        repeat (3) cyc(1'b0, 1'b0, 8'd0);
        check("reset_x", int'(x_coord), 0);
        check("reset_y", int'(y_coord), 0);
        check("reset_wren", int'(fg_wren), 0);
        check("reset_frame_start", int'(frame_start), 0);

        rst_n     = 1'b1;
        threshold = 8'd255;
        reset_bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, logic'(i[1]), 8'd0);
            if (fg_wren || frame_start || x_coord != 0 || y_coord != 0) reset_bad++;
        end
        check("no_vsync_quiet", reset_bad, 0);
        check("no_vsync_strobes", strobes, 0);
        check("no_vsync_frame_start", fs_count, 0);

        foreach (vecs[i]) begin
            threshold = vecs[i].thr;
            s0 = strobes;
            vs_pulse();
            for (int r = 0; r < 4; r++) begin
                send_line(13, r, 8'hFF, (r == 3) ? 12 : -1, vecs[i].data);
            end
            check($sformatf("thr_vec%0d_count", i), strobes - s0, vecs[i].exp_n);
        end

        threshold = 8'd128;
        s0 = strobes;
        p0 = pushes;
        f0 = fs_count;
        vs_pulse();
        for (int r = 0; r < 4; r++) begin
            send_line(H, r, 8'd200, (r == 2) ? 17 : -1, 8'd50);
        end
        check("single_count_vs_model", strobes - s0, pushes - p0);
        check("single_frame_start", fs_count - f0, 1);
`ifndef FG_ROI_EN
        check("single_count", strobes - s0, 1);
`endif

        threshold = 8'd1;
        s0 = strobes;
        p0 = pushes;
        vs_pulse();
        send_line(330, 0, 8'd0, -1, 8'd0);
        check("overlong_count_vs_model", strobes - s0, pushes - p0);
`ifndef FG_ROI_EN
        check("overlong_count", strobes - s0, H);
`endif

        threshold = 8'd128;
        s0 = strobes;
        p0 = pushes;
        f0 = fs_count;
        vs_pulse();
        for (int r = 0; r < 5; r++) send_line(40, r, 8'd200, -1, 8'd0);
        for (int c = 0; c < H; c++) begin
            if (c < 100) push_exp(c, 5);
            cyc((c >= 100) ? 1'b1 : 1'b0, 1'b1, 8'd0);
        end
        repeat (4) cyc(1'b0, 1'b0, 8'd0);
        send_line(50, 0, 8'd200, 7, 8'd0);
        check("midline_vsync_count", strobes - s0, pushes - p0);
        check("midline_frame_starts", fs_count - f0, 2);
`ifndef FG_ROI_EN
        check("midline_count", strobes - s0, 101);
`endif

        s0 = strobes;
        p0 = pushes;
        vs_pulse();
        for (int c = 0; c < 60; c++) begin
            if (c < 14) push_exp(c, 0);
            if (c == 15) rst_n = 1'b0;
            if (c == 20) rst_n = 1'b1;
            cyc(1'b0, 1'b1, (c == 14) ? 8'd200 : 8'd0);
        end
        repeat (4) cyc(1'b0, 1'b0, 8'd0);
        send_line(30, -1, 8'd0, -1, 8'd0);
        check("reset_midframe_silent", strobes - s0, pushes - p0);
        vs_pulse();
        send_line(20, 0, 8'd200, 5, 8'd0);
        check("reset_resume_count", strobes - s0, pushes - p0);

`ifdef FG_ROI_EN
        s0 = strobes;
        vs_pulse();
        for (int r = 0; r < 6; r++) send_line(H, r, 8'd0, -1, 8'd0);
        check("roi_count", strobes - s0, 20);
`endif

        repeat (5) cyc(1'b0, 1'b0, 8'd0);
        check("queue_empty", exp_q.size(), 0);
        check("total_strobes", strobes, pushes);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
